spi_txn_arbiter: RTL
====================

# spi_txn_arbiter

Round-robin arbiter and sequencer that shares one `spi_serdes` between up to `N_REQ` requesters (accelerometer poller, configuration writer, debug/host port). It accepts whole 16-bit SPI transactions from clients, drives the serdes `start`/`data_tx` handshake, and returns the 8-bit `data_rx` with a one-cycle acknowledge. A per-client lock lets a client run back-to-back transactions (e.g. X_LB then X_HB) without interleaving from other clients. It sits between the sensor-facing control logic and `spi_serdes`, in the `spi_clk` domain.

## Interface
- `N_REQ`, 4, number of requesters (2..8)
- `TIMEOUT_CYCLES`, 64, max `spi_clk` cycles from `start` rise to `done`; beyond this the transaction aborts
- `spi_clk`  in  1  sole clock, serdes clock domain
- `reset`  in  1  asynchronous, active-high reset
- `req`  in  N_REQ  per-client transaction request, held until `ack`
- `req_lock`  in  N_REQ  client keeps grant after its current transaction
- `req_tx`  in  16*N_REQ  client i's frame at `[16*i +: 16]`: {R/W, MB, addr[5:0], wdata[7:0]}
- `ack`  out  N_REQ  one-cycle completion pulse to the granted client
- `err`  out  1  valid with `ack`; 1 = aborted by timeout
- `rx_data`  out  8  read byte, valid with `ack`, held until next `ack`
- `grant`  out  N_REQ  one-hot current owner, 0 when idle
- `busy`  out  1  a transaction is in flight
- `start`  out  1  to serdes
- `data_tx`  out  16  to serdes, stable while `start`=1
- `done`  in  1  from serdes
- `data_rx`  in  8  from serdes

## Operation
- States: IDLE, ISSUE, WAIT, RELEASE, RESPOND.
- IDLE: if any `req`, pick winner by round-robin from pointer `rr_ptr` (lowest index at/after pointer); if `lock_owner` valid and its `req`=1, it wins unconditionally. Latch `req_tx` slice into `data_tx`, set `grant` -> ISSUE.
- ISSUE: `start`<=1, clear timeout counter -> WAIT.
- WAIT: count cycles. `done`=1 -> capture `data_rx` into `rx_data`, `start`<=0, `err`<=0 -> RELEASE. Counter reaches `TIMEOUT_CYCLES` -> `start`<=0, `err`<=1, `rx_data` unchanged -> RELEASE.
- RELEASE: hold `start`=0 until `done`=0 (serdes back to idle) -> RESPOND.
- RESPOND: pulse `ack[owner]`; `rr_ptr`<=owner+1 (wraps at N_REQ-1 -> 0); if `req_lock[owner]`=1 keep `lock_owner`=owner else clear it; `grant`<=0 -> IDLE.
- Lock released by the owner dropping `req_lock`, or by dropping `req` for a cycle in IDLE (lock then cleared, normal RR resumes).
- `req_tx` is ignored except at the IDLE latch; changing it mid-transaction has no effect.
- Requests for disabled/absent clients (tied 0) never granted.

## Timing
- Reset values: `start`=0, `data_tx`=0, `grant`=0, `ack`=0, `err`=0, `rx_data`=0, `busy`=0, `rr_ptr`=0, lock cleared, state IDLE.
- `req` seen in IDLE at edge n -> `grant` at n+1, `start` at n+2.
- `done` seen at edge m -> `start`=0 at m+1; `ack` earliest m+2 (if `done` already low).
- Minimum turnaround `ack` -> next `start`: 3 cycles.
- Client must hold `req` through `ack` and deassert in the `ack` cycle; `req` still high the cycle after `ack` is a new request.
- `busy`=1 from grant through RESPOND inclusive.
- Simultaneous `req` on all clients with `rr_ptr`=0: served 0,1,2,3 in order.
- `reset` mid-transaction: `start` drops asynchronously; top level drives serdes `reset_n` = ~`reset` so both abort together; no `ack` issued.

## Structure
- Package `spi_pkg`: state enum, `READ_MODE`/`WRITE_MODE` constants, `SDI_WIDTH`=16, `SDO_WIDTH`=8, register address constants shared with the poller.
- Sub-module `spi_rr_pick`: combinational round-robin one-hot picker (inputs `req`, `rr_ptr`, lock; output winner index and valid).

## Test plan
- Single client 1 sends 16'hB200 (read X_LB), serdes model returns 8'h5A after 18 cycles -> `grant`=4'b0010, `start` held until `done`, `ack`[1] one cycle, `rx_data`=8'h5A, `err`=0.
- All four `req` asserted together from reset -> `ack` order 0,1,2,3; `data_tx` matches each client's frame.
- Client 2 with `req_lock`=1 issues two reads while client 0 requests -> client 2 served twice consecutively, then client 0.
- Serdes never asserts `done` -> `start` drops after 64 cycles, `ack` with `err`=1, `rx_data` retains previous value, next request proceeds normally.
- `reset` pulsed during WAIT -> `start`, `grant`, `busy` 0 immediately, no `ack`; subsequent request completes normally from `rr_ptr`=0.
- `done` held high 3 extra cycles after `start` falls -> `ack` delayed until `done`=0, no second transaction issued.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared SPI definitions for the sensor-side SPI slice.
//   - arbiter state encoding
//   - frame field constants (R/W bit, frame widths)
//   - ADXL-style register addresses shared with the accelerometer poller
//   - spi_frame(): packs {R/W, MB, addr[5:0], wdata[7:0]}
package spi_pkg;

  localparam int SDI_WIDTH = 16;
  localparam int SDO_WIDTH = 8;

  localparam logic READ_MODE  = 1'b1;
  localparam logic WRITE_MODE = 1'b0;

  localparam logic [5:0] REG_DEVID       = 6'h00;
  localparam logic [5:0] REG_POWER_CTL   = 6'h2D;
  localparam logic [5:0] REG_DATA_FORMAT = 6'h31;
  localparam logic [5:0] REG_DATAX0      = 6'h32;
  localparam logic [5:0] REG_DATAX1      = 6'h33;
  localparam logic [5:0] REG_DATAY0      = 6'h34;
  localparam logic [5:0] REG_DATAY1      = 6'h35;
  localparam logic [5:0] REG_DATAZ0      = 6'h36;
  localparam logic [5:0] REG_DATAZ1      = 6'h37;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RELEASE,
    ST_RESPOND
  } arb_state_e;

  function automatic logic [SDI_WIDTH-1:0] spi_frame(input logic       rw,
                                                     input logic       mb,
                                                     input logic [5:0] addr,
                                                     input logic [7:0] wdata);
    return {rw, mb, addr, wdata};
  endfunction

endpackage

// File: rtl/spi_rr_pick.sv
// Combinational round-robin picker.
//   req      : per-client request vector
//   rr_ptr   : highest-priority index for this round
//   lock_vld : lock_idx holds a locked owner
//   lock_idx : locked owner, wins outright while it requests
//   win_idx  : chosen client index (valid with win_vld)
//   win_vld  : at least one eligible request
module spi_rr_pick import spi_pkg::*; #(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] rr_ptr,
  input  logic             lock_vld,
  input  logic [IDX_W-1:0] lock_idx,
  output logic [IDX_W-1:0] win_idx,
  output logic             win_vld
);

  // one spare bit so rr_ptr + k can be wrapped at N_REQ without overflow
  logic [IDX_W:0] sum;

  always_comb begin
    win_idx = '0;
    win_vld = 1'b0;
    sum     = '0;
    // walk from farthest to nearest so the first requester at/after rr_ptr
    // is the last one written
    for (int k = N_REQ-1; k >= 0; k--) begin
      sum = {1'b0, rr_ptr} + (IDX_W+1)'(k);
      if (sum >= (IDX_W+1)'(N_REQ)) sum = sum - (IDX_W+1)'(N_REQ);
      if (req[sum[IDX_W-1:0]]) begin
        win_idx = sum[IDX_W-1:0];
        win_vld = 1'b1;
      end
    end
    if (lock_vld && req[lock_idx]) begin
      win_idx = lock_idx;
      win_vld = 1'b1;
    end
  end

endmodule

// File: rtl/spi_txn_arbiter.sv
// Round-robin arbiter/sequencer sharing one spi_serdes between N_REQ clients.
//   spi_clk, reset   : clock, async active-high reset
//   req/req_lock     : per-client request (held until ack) / keep-grant
//   req_tx           : per-client 16-bit frame, sampled only when granted
//   ack/err/rx_data  : completion pulse, timeout flag, read byte
//   grant/busy       : one-hot owner, transaction in flight
//   start/data_tx    : serdes request handshake
//   done/data_rx     : serdes completion and read data
// The integrating level drives the serdes reset_n from ~reset so a reset
// aborts both blocks together; no ack is produced for an aborted transfer.
module spi_txn_arbiter import spi_pkg::*; #(
  parameter int N_REQ          = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                            spi_clk,
  input  logic                            reset,
  input  logic [N_REQ-1:0]                req,
  input  logic [N_REQ-1:0]                req_lock,
  input  logic [N_REQ-1:0][SDI_WIDTH-1:0] req_tx,
  output logic [N_REQ-1:0]                ack,
  output logic                            err,
  output logic [SDO_WIDTH-1:0]            rx_data,
  output logic [N_REQ-1:0]                grant,
  output logic                            busy,
  output logic                            start,
  output logic [SDI_WIDTH-1:0]            data_tx,
  input  logic                            done,
  input  logic [SDO_WIDTH-1:0]            data_rx
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] rr_ptr, owner, lock_idx, win_idx;
  logic             lock_vld, win_vld;
  logic [TMO_W-1:0] tmo_cnt;
  logic             tmo_hit;

  spi_rr_pick #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_pick (
    .req      (req),
    .rr_ptr   (rr_ptr),
    .lock_vld (lock_vld),
    .lock_idx (lock_idx),
    .win_idx  (win_idx),
    .win_vld  (win_vld)
  );

  // tmo_cnt holds the number of WAIT edges already seen without done;
  // start is therefore high for exactly TIMEOUT_CYCLES cycles on abort
  assign tmo_hit = (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
  assign busy    = (state_q != ST_IDLE);

  always_ff @(posedge spi_clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (win_vld) state_d = ST_ISSUE;
      ST_ISSUE:   state_d = ST_WAIT;
      ST_WAIT:    if (done || tmo_hit) state_d = ST_RELEASE;
      ST_RELEASE: if (!done) state_d = ST_RESPOND;
      ST_RESPOND: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge spi_clk or posedge reset) begin
    if (reset) begin
      start    <= 1'b0;
      data_tx  <= '0;
      grant    <= '0;
      ack      <= '0;
      err      <= 1'b0;
      rx_data  <= '0;
      rr_ptr   <= '0;
      owner    <= '0;
      lock_vld <= 1'b0;
      lock_idx <= '0;
      tmo_cnt  <= '0;
    end else begin
      ack <= '0;
      unique case (state_q)
        ST_IDLE: begin
          // owner let go of req while idle: drop the lock, plain RR resumes
          if (lock_vld && !req[lock_idx]) lock_vld <= 1'b0;
          if (win_vld) begin
            grant   <= {{(N_REQ-1){1'b0}}, 1'b1} << win_idx;
            owner   <= win_idx;
            data_tx <= req_tx[win_idx];
          end
        end
        ST_ISSUE: begin
          start   <= 1'b1;
          tmo_cnt <= '0;
        end
        ST_WAIT: begin
          if (done) begin
            start   <= 1'b0;
            rx_data <= data_rx;
            err     <= 1'b0;
          end else if (tmo_hit) begin
            start <= 1'b0;
            err   <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        ST_RELEASE: begin
          // ack is registered so it is high exactly during RESPOND
          if (!done) ack <= grant;
        end
        ST_RESPOND: begin
          rr_ptr   <= (owner == IDX_W'(N_REQ - 1)) ? '0 : owner + 1'b1;
          lock_vld <= req_lock[owner];
          lock_idx <= owner;
          grant    <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule
